// File: rtl/ibuf_sched.sv
// ibuf_sched: write scheduler and read sequencer for the instruction buffer.
//
// Purpose:
//   Two producers (port 0 = host loader, port 1 = prefetcher) share the single
//   write port of a DEPTH x DATA_WIDTH instruction buffer. Grants alternate
//   round-robin on contention. The block owns the buffer write/read pointers and
//   the stored-entry count. It presents the buffer's registered read data to the
//   decode stage as a valid/ready stream.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   p0_valid/p0_data/p0_ready  producer 0 request, word and grant
//   p1_valid/p1_data/p1_ready  producer 1 request, word and grant
//   buf_wr_en/buf_wr_addr      buffer write strobe and address
//   buf_data_in                granted producer's word
//   buf_rd_en/buf_rd_addr      buffer read strobe and address
//   buf_data_out               buffer read data, one cycle after buf_rd_en
//   out_valid/out_data         instruction stream to decode
//   out_ready                  decode accepts out_data
//   count                      stored entries, excluding the word held at the output
//   full/empty/almost_full     occupancy flags derived from count

module ibuf_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int AF_LEVEL   = 56
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         p0_valid,
    input  logic [DATA_WIDTH-1:0]        p0_data,
    output logic                         p0_ready,
    input  logic                         p1_valid,
    input  logic [DATA_WIDTH-1:0]        p1_data,
    output logic                         p1_ready,
    output logic                         buf_wr_en,
    output logic [$clog2(DEPTH)-1:0]     buf_wr_addr,
    output logic [DATA_WIDTH-1:0]        buf_data_in,
    output logic                         buf_rd_en,
    output logic [$clog2(DEPTH)-1:0]     buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]        buf_data_out,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    port_e         rr_last_q, rr_last_d;
    logic          out_valid_q, out_valid_d;

    logic can_write;
    logic gnt0;
    logic gnt1;
    logic grant;
    logic rd_issue;

    // Occupancy flags come from the registered count, so a read in a full cycle
    // only frees a write slot on the following cycle.
    assign full        = (count_q == CW'(DEPTH - 1));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign count       = count_q;

    // Arbitration and read issue. Both strobes are gated by rst so nothing is
    // granted or read while the state is being cleared. A read is only issued
    // when the output slot is free or being emptied this cycle, which keeps
    // buf_data_out stable under a held word.
    always_comb begin
        can_write   = !full && !rst;
        gnt0        = can_write && p0_valid && (!p1_valid || (rr_last_q == PORT1));
        gnt1        = can_write && p1_valid && (!p0_valid || (rr_last_q == PORT0));
        grant       = gnt0 || gnt1;
        rd_issue    = !rst && !empty && (!out_valid_q || out_ready);

        wptr_d      = grant    ? wptr_q + 1'b1 : wptr_q;
        rptr_d      = rd_issue ? rptr_q + 1'b1 : rptr_q;
        count_d     = count_q + CW'(grant) - CW'(rd_issue);

        rr_last_d   = rr_last_q;
        if (gnt0) begin
            rr_last_d = PORT0;
        end else if (gnt1) begin
            rr_last_d = PORT1;
        end

        out_valid_d = out_valid_q;
        if (rd_issue) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign p0_ready    = gnt0;
    assign p1_ready    = gnt1;
    assign buf_wr_en   = grant;
    assign buf_wr_addr = wptr_q;
    assign buf_data_in = gnt1 ? p1_data : p0_data;
    assign buf_rd_en   = rd_issue;
    assign buf_rd_addr = rptr_q;
    assign out_valid   = out_valid_q;
    assign out_data    = buf_data_out;

    // State registers. Reset discards stored and held words and makes port 0
    // the winner of the next contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rr_last_q   <= PORT1;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rr_last_q   <= rr_last_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ibuf_sched.sv
module tb_ibuf_sched;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_valid, p1_valid;
    logic [DW-1:0] p0_data, p1_data;
    logic          p0_ready, p1_ready;
    logic          buf_wr_en, buf_rd_en;
    logic [5:0]    buf_wr_addr, buf_rd_addr;
    logic [DW-1:0] buf_data_in, bufDataOut;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [6:0]    count;
    logic          full, empty, almost_full;

    logic [DW-1:0] mem [64];

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sbQ [$];
    logic [5:0]    expWptr = '0;
    logic [5:0]    expRptr = '0;
    logic          prevHold = 1'b0;
    logic [DW-1:0] prevData = '0;
    int            accepted = 0;
    int            cyc;
    int            e;

    always #5 clk = ~clk;

    ibuf_sched #(
        .DATA_WIDTH(32),
        .DEPTH(64),
        .AF_LEVEL(56)
    ) dut (
        .clk(clk),
        .rst(rst),
        .p0_valid(p0_valid),
        .p0_data(p0_data),
        .p0_ready(p0_ready),
        .p1_valid(p1_valid),
        .p1_data(p1_data),
        .p1_ready(p1_ready),
        .buf_wr_en(buf_wr_en),
        .buf_wr_addr(buf_wr_addr),
        .buf_data_in(buf_data_in),
        .buf_rd_en(buf_rd_en),
        .buf_rd_addr(buf_rd_addr),
        .buf_data_out(bufDataOut),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full)
    );

    // Behavioural 64x32 buffer with registered read data.
    always @(posedge clk) begin
        if (buf_wr_en) mem[buf_wr_addr] <= buf_data_in;
        if (buf_rd_en) bufDataOut <= mem[buf_rd_addr];
    end

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] d0,
                                 input logic v1, input logic [31:0] d1,
                                 input logic ordy);
        p0_valid  = v0;
        p0_data   = d0;
        p1_valid  = v1;
        p1_data   = d1;
        out_ready = ordy;
    endtask

    // Mid-cycle sample: tracks every accepted word in a scoreboard and checks
    // addresses, delivered order and hold stability.
    task automatic sample();
        logic [31:0] d;
        @(negedge clk);
        if (rst) begin
            sbQ.delete();
            expWptr  = '0;
            expRptr  = '0;
            prevHold = 1'b0;
        end else begin
            if (prevHold) begin
                checkWord("hold_data", out_data, prevData);
                checkBit("hold_valid", out_valid, 1'b1);
            end
            checkBit("one_grant", p0_ready & p1_ready, 1'b0);
            if (p0_ready || p1_ready) begin
                d = p0_ready ? p0_data : p1_data;
                checkBit("wr_en", buf_wr_en, 1'b1);
                checkWord("wr_data", buf_data_in, d);
                checkWord("wr_addr", 32'(buf_wr_addr), 32'(expWptr));
                sbQ.push_back(d);
                expWptr++;
                accepted++;
            end
            if (buf_rd_en) begin
                checkWord("rd_addr", 32'(buf_rd_addr), 32'(expRptr));
                expRptr++;
            end
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) checkBit("sb_empty", out_valid, 1'b0);
                else checkWord("out_data", out_data, sbQ.pop_front());
            end
            prevHold = out_valid && !out_ready;
            prevData = out_data;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset, including a request that must not be granted while rst is high
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b0);
        sample();
        checkBit("rst_p0_ready", p0_ready, 1'b0);
        checkBit("rst_p1_ready", p1_ready, 1'b0);
        checkBit("rst_wr_en", buf_wr_en, 1'b0);
        checkBit("rst_rd_en", buf_rd_en, 1'b0);
        advance();
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        sample();
        checkWord("rst_count", 32'(count), 32'd0);
        checkBit("rst_empty", empty, 1'b1);
        checkBit("rst_full", full, 1'b0);
        checkBit("rst_af", almost_full, 1'b0);
        checkBit("rst_out_valid", out_valid, 1'b0);
        advance();

        // Three words from p0 with decode always ready
        applyStimulus(1'b1, 32'hA000_0001, 1'b0, '0, 1'b1);
        sample();
        checkBit("t1_c0_ready", p0_ready, 1'b1);
        checkWord("t1_c0_addr", 32'(buf_wr_addr), 32'd0);
        checkBit("t1_c0_valid", out_valid, 1'b0);
        advance();
        applyStimulus(1'b1, 32'hA000_0002, 1'b0, '0, 1'b1);
        sample();
        checkWord("t1_c1_addr", 32'(buf_wr_addr), 32'd1);
        checkBit("t1_c1_rd_en", buf_rd_en, 1'b1);
        checkWord("t1_c1_count", 32'(count), 32'd1);
        checkBit("t1_c1_valid", out_valid, 1'b0);
        advance();
        applyStimulus(1'b1, 32'hA000_0003, 1'b0, '0, 1'b1);
        sample();
        checkWord("t1_c2_addr", 32'(buf_wr_addr), 32'd2);
        checkBit("t1_c2_valid", out_valid, 1'b1);
        checkWord("t1_c2_data", out_data, 32'hA000_0001);
        advance();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        sample();
        checkWord("t1_c3_data", out_data, 32'hA000_0002);
        checkWord("t1_c3_count", 32'(count), 32'd1);
        advance();
        sample();
        checkWord("t1_c4_data", out_data, 32'hA000_0003);
        checkWord("t1_c4_count", 32'(count), 32'd0);
        checkBit("t1_c4_rd_en", buf_rd_en, 1'b0);
        advance();
        sample();
        checkBit("t1_c5_valid", out_valid, 1'b0);
        advance();

        // Contention: grants alternate starting with p0 after reset
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'hB000_0000 + 32'(i), 1'b1, 32'hC000_0000 + 32'(i), 1'b1);
            sample();
            checkBit("rr_p0", p0_ready, (i % 2) == 0);
            checkBit("rr_p1", p1_ready, (i % 2) == 1);
            advance();
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (6) step();
        sample();
        checkBit("rr_drain_empty", empty, 1'b1);
        checkBit("rr_drain_valid", out_valid, 1'b0);
        advance();

        // Fill with decode stalled: 63 stored plus one held at the output
        doReset();
        accepted = 0;
        for (int k = 0; k < 68; k++) begin
            e = (k == 0) ? 0 : (k == 1) ? 1 : ((k - 1 > 63) ? 63 : k - 1);
            applyStimulus(1'b1, 32'hD000_0000 + 32'(accepted), 1'b0, '0, 1'b0);
            sample();
            checkWord("fill_count", 32'(count), 32'(e));
            checkBit("fill_af", almost_full, e >= 56);
            checkBit("fill_full", full, e == 63);
            checkBit("fill_p0_ready", p0_ready, e < 63);
            advance();
        end
        checkWord("fill_accepted", 32'(accepted), 32'd64);
        sample();
        checkBit("fill_out_valid", out_valid, 1'b1);
        checkWord("fill_out_data", out_data, 32'hD000_0000);
        advance();

        // One-cycle out_ready pulse while full: write slot opens next cycle
        applyStimulus(1'b1, 32'hD000_0000 + 32'(accepted), 1'b0, '0, 1'b1);
        sample();
        checkBit("pulse_ready", p0_ready, 1'b0);
        checkBit("pulse_rd_en", buf_rd_en, 1'b1);
        advance();
        applyStimulus(1'b1, 32'hD000_0000 + 32'(accepted), 1'b0, '0, 1'b0);
        sample();
        checkWord("pulse_count62", 32'(count), 32'd62);
        checkBit("pulse_grant", p0_ready, 1'b1);
        advance();
        applyStimulus(1'b1, 32'hD000_0000 + 32'(accepted), 1'b0, '0, 1'b0);
        sample();
        checkWord("pulse_count63", 32'(count), 32'd63);
        checkBit("pulse_noready", p0_ready, 1'b0);
        advance();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (70) step();
        sample();
        checkBit("fill_drain_empty", empty, 1'b1);
        checkBit("fill_drain_valid", out_valid, 1'b0);
        advance();

        // Stream 150 words with out_ready toggling; pointers wrap
        accepted = 0;
        cyc = 0;
        while (accepted < 150 && cyc < 1000) begin
            applyStimulus(1'b1, 32'hE000_0000 + 32'(accepted), 1'b0, '0, (cyc % 2) == 1);
            step();
            cyc++;
        end
        checkWord("stream_accepted", 32'(accepted), 32'd150);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (80) step();
        sample();
        checkBit("stream_empty", empty, 1'b1);
        checkBit("stream_valid", out_valid, 1'b0);
        checkWord("stream_count", 32'(count), 32'd0);
        advance();

        // Reset with 10 stored and one held word
        doReset();
        for (int k = 0; k < 11; k++) begin
            applyStimulus(1'b1, 32'hF000_0000 + 32'(k), 1'b0, '0, 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        sample();
        checkWord("pre_rst_count", 32'(count), 32'd10);
        checkBit("pre_rst_valid", out_valid, 1'b1);
        advance();
        rst = 1'b1;
        applyStimulus(1'b1, 32'h5000_0000, 1'b1, 32'h6000_0000, 1'b0);
        sample();
        checkBit("mid_rst_p0", p0_ready, 1'b0);
        checkBit("mid_rst_p1", p1_ready, 1'b0);
        checkBit("mid_rst_rd_en", buf_rd_en, 1'b0);
        advance();
        rst = 1'b0;
        sample();
        checkWord("post_rst_count", 32'(count), 32'd0);
        checkBit("post_rst_valid", out_valid, 1'b0);
        checkBit("post_rst_empty", empty, 1'b1);
        checkBit("post_rst_p0", p0_ready, 1'b1);
        checkBit("post_rst_p1", p1_ready, 1'b0);
        checkWord("post_rst_wr_addr", 32'(buf_wr_addr), 32'd0);
        advance();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        sample();
        checkBit("post_rst_rd_en", buf_rd_en, 1'b1);
        checkWord("post_rst_rd_addr", 32'(buf_rd_addr), 32'd0);
        advance();
        sample();
        checkWord("post_rst_data", out_data, 32'h5000_0000);
        advance();
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
